// File: rtl/dff_chain_delay_ctrl.sv
// DEPTH-stage single-bit delay chain with a programmable output tap, fill tracking,
// run-time delay reconfiguration over a valid/ready handshake and a multi-cycle zeroing flush.
module dff_chain_delay_ctrl #(
    parameter int DEPTH         = 8,
    parameter int TAP_W         = 4,
    parameter int DEFAULT_DELAY = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             in,
    input  logic             cfg_valid,
    input  logic [TAP_W-1:0] cfg_delay,
    output logic             cfg_ready,
    output logic             cfg_err,
    input  logic             flush_req,
    output logic             flush_done,
    output logic             busy,
    output logic             out,
    output logic             out_valid,
    output logic [1:0]       dbg_state,
    output logic [TAP_W-1:0] dbg_valid_cnt,
    output logic [TAP_W-1:0] dbg_cur_delay
);

    // Handshake: a cfg request transfers on a rising edge where cfg_valid && cfg_ready;
    // cfg_valid is ignored while cfg_ready is low (FLUSH).

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam int              TAPS       = 1 << TAP_W;
    localparam logic [TAP_W-1:0] DEPTH_V    = TAP_W'(DEPTH);
    localparam logic [TAP_W-1:0] LAST_FLUSH = TAP_W'(DEPTH - 1);
    localparam logic [TAP_W-1:0] DEF_V      = TAP_W'(DEFAULT_DELAY);
    localparam logic [TAP_W-1:0] ONE        = TAP_W'(1);

    state_t             state, state_n;
    logic [DEPTH-1:0]   chain, chain_n;
    logic [TAP_W-1:0]   valid_cnt, valid_cnt_n;
    logic [TAP_W-1:0]   flush_cnt, flush_cnt_n;
    logic [TAP_W-1:0]   cur_delay, cur_delay_n;
    logic               cfg_err_q, cfg_err_n;
    logic               flush_done_q, flush_done_n;
    logic               cfg_acc, cfg_legal;
    logic [TAPS-1:0]    tap_vec;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= S_FILL;
            chain        <= '0;
            valid_cnt    <= '0;
            flush_cnt    <= '0;
            cur_delay    <= DEF_V;
            cfg_err_q    <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state        <= state_n;
            chain        <= chain_n;
            valid_cnt    <= valid_cnt_n;
            flush_cnt    <= flush_cnt_n;
            cur_delay    <= cur_delay_n;
            cfg_err_q    <= cfg_err_n;
            flush_done_q <= flush_done_n;
        end
    end

    always_comb begin
        state_n      = state;
        chain_n      = chain;
        valid_cnt_n  = valid_cnt;
        flush_cnt_n  = flush_cnt;
        cur_delay_n  = cur_delay;
        cfg_err_n    = 1'b0;
        flush_done_n = 1'b0;
        cfg_acc      = cfg_valid && (state != S_FLUSH);
        cfg_legal    = (cfg_delay != '0) && (cfg_delay <= DEPTH_V);

        case (state)
            S_FLUSH: begin
                chain_n = {chain[DEPTH-2:0], 1'b0};
                if (flush_cnt == LAST_FLUSH) begin
                    state_n      = S_FILL;
                    valid_cnt_n  = '0;
                    flush_cnt_n  = '0;
                    flush_done_n = 1'b1;
                end else begin
                    flush_cnt_n = flush_cnt + ONE;
                end
            end
            default: begin
                // The cfg request applies even on an edge that also starts a flush.
                if (cfg_acc) begin
                    if (cfg_legal) cur_delay_n = cfg_delay;
                    else           cfg_err_n   = 1'b1;
                end
                if (flush_req) begin
                    state_n     = S_FLUSH;
                    flush_cnt_n = '0;
                end else begin
                    if (en) begin
                        chain_n = {chain[DEPTH-2:0], in};
                        if (valid_cnt != DEPTH_V) valid_cnt_n = valid_cnt + ONE;
                    end
                    state_n = (valid_cnt_n >= cur_delay_n) ? S_RUN : S_FILL;
                end
            end
        endcase
    end

    always_comb begin
        // Zero-extend so the tap index is full width; cur_delay never exceeds DEPTH.
        tap_vec       = TAPS'(chain);
        out           = tap_vec[cur_delay - ONE];
        out_valid     = (state == S_RUN);
        busy          = (state == S_FLUSH);
        cfg_ready     = (state != S_FLUSH);
        cfg_err       = cfg_err_q;
        flush_done    = flush_done_q;
        dbg_state     = state;
        dbg_valid_cnt = valid_cnt;
        dbg_cur_delay = cur_delay;
    end

endmodule
